// File: rtl/multicycle_subtractor_if.sv
// Start/done handshake and operand/result bundle for multicycle_subtractor.
// master = requester side, slave = the subtract unit.
interface multicycle_subtractor_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/multicycle_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock, LSB slice first.
// Define SUB_SIGNED_OVF_EN to generate the signed-overflow output; otherwise ovf is tied to 0.
module multicycle_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_subtractor_if.slave bus
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sl_res;

    // Current slice of each operand and its difference; sl_res[CHUNK] is the slice borrow-out.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                a_sl = a_q[s*CHUNK +: CHUNK];
                b_sl = b_q[s*CHUNK +: CHUNK];
            end
        end
        sl_res = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, brw_q};
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    diff_d  = '0;
                    bout_d  = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            CALC: begin
                for (int s = 0; s < NSLICE; s++) begin
                    if (cnt_q == CNT_W'(s)) diff_d[s*CHUNK +: CHUNK] = sl_res[CHUNK-1:0];
                end
                brw_d = sl_res[CHUNK];
                if (cnt_q == LAST_SLICE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    bout_d  = sl_res[CHUNK];
`ifdef SUB_SIGNED_OVF_EN
                    // Borrow into the MSB recovered from the full-subtractor sum bit: a ^ b ^ r.
                    ovf_d   = (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sl_res[CHUNK-1]) ^ sl_res[CHUNK];
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign bus.ovf  = ovf_q;
`else
    assign bus.ovf  = 1'b0;
`endif

endmodule
